// File: rtl/mux4_rr_collector_if.sv
// Lane-side and sink-side handshake bundle for mux4_rr_collector.
// With MUX4_PKT_LOCK_EN defined it also carries in_last/out_last packet framing.
interface mux4_rr_collector_if #(
  parameter int DW = 8
);
  logic [3:0]      in_valid;
  logic [4*DW-1:0] in_data;
  logic [3:0]      in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_sel0;
  logic            out_sel1;
  logic            out_ready;
`ifdef MUX4_PKT_LOCK_EN
  logic [3:0]      in_last;
  logic            out_last;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sel0, out_sel1, out_last
  );
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sel0, out_sel1, out_last
  );
`else
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel0, out_sel1
  );
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel0, out_sel1
  );
`endif
endinterface

// File: rtl/mux4_rr_collector.sv
// Round-robin merge of four valid/ready lanes into one registered, lane-tagged output word.
// Optional packet lock (grant held on a lane until its in_last word) when MUX4_PKT_LOCK_EN is defined.
module mux4_rr_collector #(
  parameter int DW = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  mux4_rr_collector_if.slave bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [1:0]    ptr, ptr_nxt;
  logic [DW-1:0] data_q;
  logic [1:0]    sel_q;
  logic [3:0]    req;
  logic [1:0]    grant;
  logic          ld;
  logic          xfer;
`ifdef MUX4_PKT_LOCK_EN
  logic          locked, locked_nxt;
  logic          last_q;
`endif

  always_comb begin
    req = bus.in_valid;
`ifdef MUX4_PKT_LOCK_EN
    // While locked, the held word's lane (sel_q) is the only lane allowed to compete.
    if (locked) req = bus.in_valid & (4'b0001 << sel_q);
`endif

    // Walk downward so the lane closest to ptr wins.
    grant = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) grant = ptr + 2'(k);
    end

    ld           = (state == EMPTY) | bus.out_ready;
    xfer         = ld & (|req) & rst_n;
    bus.in_ready = xfer ? (4'b0001 << grant) : 4'b0000;

    state_nxt = state;
    ptr_nxt   = ptr;
`ifdef MUX4_PKT_LOCK_EN
    locked_nxt = locked;
`endif
    if (xfer) begin
      state_nxt = FULL;
      ptr_nxt   = grant + 2'd1;
`ifdef MUX4_PKT_LOCK_EN
      if (!bus.in_last[grant]) begin
        locked_nxt = 1'b1;
        ptr_nxt    = ptr;
      end else begin
        locked_nxt = 1'b0;
      end
`endif
    end else if (ld) begin
      state_nxt = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= EMPTY;
      ptr    <= 2'd0;
      data_q <= '0;
      sel_q  <= 2'd0;
`ifdef MUX4_PKT_LOCK_EN
      locked <= 1'b0;
      last_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
`ifdef MUX4_PKT_LOCK_EN
      locked <= locked_nxt;
`endif
      if (xfer) begin
        data_q <= bus.in_data[int'(grant)*DW +: DW];
        sel_q  <= grant;
`ifdef MUX4_PKT_LOCK_EN
        last_q <= bus.in_last[grant];
`endif
      end
    end
  end

  assign bus.out_valid = (state == FULL);
  assign bus.out_data  = data_q;
  assign bus.out_sel0  = sel_q[0];
  assign bus.out_sel1  = sel_q[1];
`ifdef MUX4_PKT_LOCK_EN
  assign bus.out_last  = last_q;
`endif

endmodule

// File: tb/tb_mux4_rr_collector.sv
// Scoreboard bench for mux4_rr_collector: directed scenarios plus randomized traffic against a lane-level model.
// Build with MUX4_PKT_LOCK_EN defined to exercise packet locking.
module tb_mux4_rr_collector;

  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mux4_rr_collector_if #(.DW(DW)) bus ();

  mux4_rr_collector #(.DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] data;
    logic [1:0] lane;
    logic       last;
  } word_t;

  word_t      sb[$];
  word_t      cw;
  word_t      mw;
  int         total = 0;
  int         bad = 0;
  bit         armed = 0;
  logic [7:0] lane_data[4];
  logic [7:0] drv_data[4];
  logic [3:0] drv_last;

  // Model state: what the collector should hold after the most recent edge.
  int ptr_m = 0;
  bit full_m = 0;
  bit lock_m = 0;
  int lock_lane_m = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one set of inputs per cycle at the falling edge, for n cycles.
  task automatic applyStimulus(input logic rst, input logic [3:0] v, input logic r,
                               input logic [3:0] last, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      rst_n         = rst;
      bus.in_valid  = v;
      bus.out_ready = r;
      for (int i = 0; i < 4; i++) begin
        drv_data[i]            = lane_data[i];
        bus.in_data[i*DW +: DW] = lane_data[i];
      end
      drv_last = last;
`ifdef MUX4_PKT_LOCK_EN
      bus.in_last = last;
`endif
    end
  endtask

  // Reference model: predicts in_ready from the arbitration rules and queues granted words.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (armed) begin
        logic [3:0] exp_rdy;
        int         g;
        bit         ld;
        exp_rdy = 4'b0000;
        g       = -1;
        ld      = 1'b0;
        if (rst_n === 1'b1) begin
          ld = !full_m || (bus.out_ready === 1'b1);
          if (ld) begin
            if (lock_m) begin
              if (bus.in_valid[lock_lane_m]) g = lock_lane_m;
            end else begin
              for (int k = 0; k < 4; k++)
                if (g < 0 && bus.in_valid[(ptr_m + k) % 4]) g = (ptr_m + k) % 4;
            end
          end
          if (g >= 0) exp_rdy[g] = 1'b1;
        end
        checkOutput("in_ready", {28'd0, bus.in_ready}, {28'd0, exp_rdy});
        if (rst_n !== 1'b1) begin
          ptr_m  = 0;
          full_m = 0;
          lock_m = 0;
          sb.delete();
        end else if (g >= 0) begin
          cw.data = drv_data[g];
          cw.lane = 2'(g);
`ifdef MUX4_PKT_LOCK_EN
          cw.last = drv_last[g];
          if (!drv_last[g]) begin
            lock_m      = 1;
            lock_lane_m = g;
          end else begin
            lock_m = 0;
            ptr_m  = (g + 1) % 4;
          end
`else
          cw.last = 1'b0;
          ptr_m   = (g + 1) % 4;
`endif
          sb.push_back(cw);
          full_m = 1;
        end else if (ld) begin
          full_m = 0;
        end
      end
    end
  end

  // Monitor: the held word must match the oldest queued word until the sink accepts it.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (armed) begin
        checkOutput("out_valid", {31'd0, bus.out_valid}, {31'd0, (sb.size() > 0)});
        if (bus.out_valid === 1'b1 && sb.size() > 0) begin
          mw = sb[0];
          checkOutput("out_data", {24'd0, bus.out_data}, {24'd0, mw.data});
          checkOutput("out_sel", {30'd0, bus.out_sel1, bus.out_sel0}, {30'd0, mw.lane});
`ifdef MUX4_PKT_LOCK_EN
          checkOutput("out_last", {31'd0, bus.out_last}, {31'd0, mw.last});
`endif
          if (bus.out_ready === 1'b1) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      lane_data[i]            = 8'hA0 + 8'(i);
      drv_data[i]             = lane_data[i];
      bus.in_data[i*DW +: DW] = lane_data[i];
    end
    drv_last = 4'b1111;
`ifdef MUX4_PKT_LOCK_EN
    bus.in_last = 4'b1111;
`endif

    @(posedge clk);
    #1;
    armed = 1;
    @(posedge clk);
    #1;
    checkOutput("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("rst_out_data", {24'd0, bus.out_data}, 32'd0);
    checkOutput("rst_out_sel", {30'd0, bus.out_sel1, bus.out_sel0}, 32'd0);
    checkOutput("rst_in_ready", {28'd0, bus.in_ready}, 32'd0);

    $display("[TB] all lanes streaming");
    applyStimulus(1'b1, 4'b1111, 1'b1, 4'b1111, 6);
    $display("[TB] lanes 1 and 3 from ptr 2");
    applyStimulus(1'b1, 4'b1010, 1'b1, 4'b1111, 4);

    $display("[TB] backpressure");
    lane_data[2] = 8'h55;
    lane_data[0] = 8'h0F;
    applyStimulus(1'b1, 4'b0100, 1'b1, 4'b1111, 1);
    applyStimulus(1'b1, 4'b0001, 1'b0, 4'b1111, 3);
    applyStimulus(1'b1, 4'b0001, 1'b1, 4'b1111, 1);

    $display("[TB] drain");
    lane_data[1] = 8'h3C;
    applyStimulus(1'b1, 4'b0010, 1'b1, 4'b1111, 1);
    applyStimulus(1'b1, 4'b0000, 1'b1, 4'b1111, 3);
    @(posedge clk);
    #1;
    checkOutput("drain_data_hold", {24'd0, bus.out_data}, 32'h3C);
    checkOutput("drain_sel_hold", {30'd0, bus.out_sel1, bus.out_sel0}, 32'd1);

`ifdef MUX4_PKT_LOCK_EN
    $display("[TB] packet lock on lane 2");
    lane_data[0] = 8'hE0;
    lane_data[2] = 8'h21;
    applyStimulus(1'b1, 4'b0100, 1'b1, 4'b0000, 1);
    applyStimulus(1'b1, 4'b0001, 1'b1, 4'b0000, 1);
    lane_data[2] = 8'h22;
    applyStimulus(1'b1, 4'b0101, 1'b1, 4'b0000, 1);
    lane_data[2] = 8'h23;
    applyStimulus(1'b1, 4'b0101, 1'b1, 4'b0100, 1);
    applyStimulus(1'b1, 4'b0101, 1'b1, 4'b1111, 2);
`endif

    $display("[TB] randomized traffic");
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) lane_data[i] = 8'($urandom);
      applyStimulus((n % 150) != 149, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                    4'($urandom_range(0, 15)), 1);
    end

    applyStimulus(1'b1, 4'b0000, 1'b1, 4'b1111, 3);
    @(posedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
